// File: rtl/dff_if.sv
// Data-side bundle of the D flip-flop: d in, q/qn out.
// Binds the cell's data pins from a parent block without repeating the width.
`timescale 1ns/1ps
interface dff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;

    modport master (output d, input q, input qn);
    modport slave  (input d, output q, output qn);
endinterface

// File: rtl/dff.sv
// D flip-flop leaf cell with complementary outputs and synchronous reset.
// Plain ports in the order (d, clk, rst, q, qn) so positional instantiations keep working.
`timescale 1ns/1ps
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);
    logic [WIDTH-1:0] q_reg;

    // Each bit is an independent storage element sharing clk and rst.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg[gi] <= RESET_VALUE[gi];
                end else begin
                    q_reg[gi] <= d[gi];
                end
            end
        end
    endgenerate

    assign q  = q_reg;
    assign qn = ~q_reg;
endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: 1-bit default cell and an 8-bit cell with reset value A5.
`timescale 1ns/1ps
module tb_dff;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    dff_if #(.WIDTH(1)) if1 ();
    dff_if #(.WIDTH(8)) if8 ();

    dff u_dff1 (
        .d  (if1.d),
        .clk(clk),
        .rst(rst),
        .q  (if1.q),
        .qn (if1.qn)
    );

    dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dff8 (
        .d  (if8.d),
        .clk(clk),
        .rst(rst),
        .q  (if8.q),
        .qn (if8.qn)
    );

    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        $display("check %-14s got=%h exp=%h", tag, got, exp);
    endtask

    // Advance past one rising edge and sample on the falling edge; qn == ~q every cycle.
    task automatic step();
        @(negedge clk);
        chk("inv1", {7'b0, if1.qn}, {7'b0, ~if1.q});
        chk("inv8", if8.qn, ~if8.q);
    endtask

    initial begin
        rst    = 1'b1;
        if1.d  = 1'b1;
        if8.d  = 8'hFF;

        // Reset from unknown state, d ignored
        step();
        chk("rst_q", {7'b0, if1.q}, 8'h00);
        chk("rst_qn", {7'b0, if1.qn}, 8'h01);
        chk("rst_q8", if8.q, 8'hA5);
        chk("rst_qn8", if8.qn, 8'h5A);
        step();
        chk("rst_hold", {7'b0, if1.q}, 8'h00);

        // Capture
        rst = 1'b0; if1.d = 1'b1;
        step();
        chk("cap1_q", {7'b0, if1.q}, 8'h01);
        chk("cap1_qn", {7'b0, if1.qn}, 8'h00);
        chk("cap_q8", if8.q, 8'hFF);
        if1.d = 1'b0;
        step();
        chk("cap0_q", {7'b0, if1.q}, 8'h00);
        chk("cap0_qn", {7'b0, if1.qn}, 8'h01);

        // Hold: d toggles between edges, q follows only at the edge
        if1.d = 1'b1;
        step();
        chk("hold_pre", {7'b0, if1.q}, 8'h01);
        if1.d = 1'b0;
        #0.3;
        chk("hold_mid0", {7'b0, if1.q}, 8'h01);
        if1.d = 1'b1;
        #0.3;
        chk("hold_mid1", {7'b0, if1.q}, 8'h01);
        if1.d = 1'b0;
        step();
        chk("hold_edge", {7'b0, if1.q}, 8'h00);

        // Mid-stream reset: rst wins over d
        if1.d = 1'b1;
        step();
        chk("mid_pre", {7'b0, if1.q}, 8'h01);
        rst = 1'b1; if1.d = 1'b1;
        step();
        chk("mid_rst_q", {7'b0, if1.q}, 8'h00);
        chk("mid_rst_qn", {7'b0, if1.qn}, 8'h01);
        rst = 1'b0;
        step();
        chk("mid_rel", {7'b0, if1.q}, 8'h01);

        // Short reset pulse that spans no rising edge
        rst = 1'b1;
        #0.3;
        rst = 1'b0;
        step();
        chk("short_q", {7'b0, if1.q}, 8'h01);
        chk("short_q8", if8.q, 8'hFF);

        // 8-bit cell: reset value then capture
        rst = 1'b1;
        step();
        chk("w8_rst_q", if8.q, 8'hA5);
        chk("w8_rst_qn", if8.qn, 8'h5A);
        rst = 1'b0; if8.d = 8'h3C;
        step();
        chk("w8_cap_q", if8.q, 8'h3C);
        chk("w8_cap_qn", if8.qn, 8'hC3);
        if8.d = 8'h81;
        step();
        chk("w8_cap2_q", if8.q, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
